// File: rtl/temp_frame_pkg.sv
// Shared constants and FSM encoding for the temperature frame packer.
// Frames on the wire: HDR0 HDR1 LEN payload CSUM.
package temp_frame_pkg;

    localparam logic [7:0] HDR0_DEF = 8'hAA;
    localparam logic [7:0] HDR1_DEF = 8'h55;
    localparam int         CSUM_W   = 8;

    // Each state names the byte the output register loads next.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SH0,
        ST_SH1,
        ST_SLEN,
        ST_SPAY,
        ST_SCSUM
    } state_t;

    function automatic logic [7:0] min_len(input logic [10:0] used, input logic [10:0] cap);
        return (used >= cap) ? cap[7:0] : used[7:0];
    endfunction

endpackage

// File: rtl/frame_flush_timer.sv
// Saturating idle counter; flags when a partial frame has waited long enough to flush.
// A TIMEOUT_CYC of 0 disables flushing entirely.
module frame_flush_timer #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TMR_W       = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYC);

    logic [TMR_W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYC != 0) && (count == LIMIT);

endmodule

// File: rtl/temp_frame_packer.sv
// Drains the show-ahead sample FIFO into HDR0 HDR1 LEN payload CSUM frames
// on a valid/ready byte stream, through a single output register.
module temp_frame_packer
    import temp_frame_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 16,
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         TMR_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    input  logic [10:0] fifo_rdusedw,
    output logic        fifo_re,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] CAP = 11'(PAYLOAD_LEN);

    state_t              state, state_d;
    logic [7:0]          len_q;
    logic [7:0]          remaining;
    logic [CSUM_W-1:0]   csum_q;
    logic                csum_out;
    logic                tmr_expired;
    logic                full_avail;
    logic                start;
    logic                load_ok;
    logic                pending;
    logic                load_en;
    logic [7:0]          load_byte;

    assign full_avail = (fifo_rdusedw >= CAP);
    assign start      = (state == ST_IDLE) && (full_avail || (tmr_expired && !fifo_empty));
    assign load_ok    = !tx_valid || tx_ready;
    assign load_en    = pending && load_ok;
    assign busy       = (state != ST_IDLE);
    // The CSUM byte is tracked separately because the FSM is already back in IDLE while it is presented.
    assign frame_done = tx_valid && tx_ready && csum_out;

    frame_flush_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_flush_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start || fifo_empty || (state != ST_IDLE)),
        .en      ((state == ST_IDLE) && !fifo_empty && !full_avail),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        pending   = 1'b0;
        load_byte = 8'h00;
        fifo_re   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Loading HDR0 in the start cycle keeps back-to-back frames gapless.
                if (start) begin
                    pending   = 1'b1;
                    load_byte = HDR0;
                    state_d   = load_ok ? ST_SH1 : ST_SH0;
                end
            end
            ST_SH0: begin
                pending   = 1'b1;
                load_byte = HDR0;
                if (load_ok) state_d = ST_SH1;
            end
            ST_SH1: begin
                pending   = 1'b1;
                load_byte = HDR1;
                if (load_ok) state_d = ST_SLEN;
            end
            ST_SLEN: begin
                pending   = 1'b1;
                load_byte = len_q;
                if (load_ok) state_d = ST_SPAY;
            end
            ST_SPAY: begin
                pending   = 1'b1;
                load_byte = fifo_dout;
                fifo_re   = load_ok;
                if (load_ok && (remaining == 8'd1)) state_d = ST_SCSUM;
            end
            ST_SCSUM: begin
                pending   = 1'b1;
                load_byte = csum_q;
                if (load_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            csum_out  <= 1'b0;
            len_q     <= 8'h00;
            remaining <= 8'h00;
            csum_q    <= '0;
            frame_cnt <= 16'h0000;
        end else begin
            if (load_en) begin
                tx_data  <= load_byte;
                tx_valid <= 1'b1;
                csum_out <= (state == ST_SCSUM);
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
                csum_out <= 1'b0;
            end

            if (start) begin
                len_q  <= min_len(fifo_rdusedw, CAP);
                csum_q <= '0;
            end else if (load_en && (state == ST_SLEN)) begin
                csum_q    <= len_q;
                remaining <= len_q;
            end else if (load_en && (state == ST_SPAY)) begin
                csum_q    <= csum_q + fifo_dout;
                remaining <= remaining - 8'd1;
            end

            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
